// File: rtl/xfer_sched.sv
// Transfer controller moving bytes from the deserializer into the byte queue, with
// clock-enable ticks, queue back-pressure and an ack timeout. Define XFER_STATS_EN for counters.
module xfer_sched #(
    parameter int DES_DIV     = 10,
    parameter int Q_DIV       = 100,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic       des_tick_o,
    output logic       q_tick_o,
    input  logic [7:0] des_data_i,
    input  logic       des_ready_i,
    output logic       des_ack_o,
    input  logic [3:0] q_len_i,
    output logic [7:0] q_data_o,
    output logic       q_enqueue_o,
    output logic       stall_o,
    output logic       err_o
`ifdef XFER_STATS_EN
    ,
    output logic [15:0] xfer_cnt_o,
    output logic [15:0] stall_cnt_o
`endif
);

    localparam int DW = $clog2(DES_DIV + 1);
    localparam int QW = $clog2(Q_DIV + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DES_LAST = DW'(DES_DIV - 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(Q_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]    DEPTH_L  = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, STALL, ENQ, ACK} state_t;

    logic [DW-1:0] des_cnt_q, des_cnt_d;
    logic [QW-1:0] q_cnt_q, q_cnt_d;
    logic          des_tick_q, des_tick_d;
    logic          q_tick_q, q_tick_d;

    state_t        state_q, state_d;
    logic [7:0]    q_data_q, q_data_d;
    logic          ack_q, ack_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;
    logic [TW-1:0] to_q, to_d;
    logic          stall_evt;
    logic          space_ok;

    // Ticks are registered so each enable is high in the cycle its counter sits at DIV-1.
    always_comb begin
        des_cnt_d  = (des_cnt_q == DES_LAST) ? '0 : des_cnt_q + DW'(1);
        q_cnt_d    = (q_cnt_q == Q_LAST) ? '0 : q_cnt_q + QW'(1);
        des_tick_d = (des_cnt_d == DES_LAST);
        q_tick_d   = (q_cnt_d == Q_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            des_cnt_q  <= '0;
            q_cnt_q    <= '0;
            des_tick_q <= 1'b0;
            q_tick_q   <= 1'b0;
        end else begin
            des_cnt_q  <= des_cnt_d;
            q_cnt_q    <= q_cnt_d;
            des_tick_q <= des_tick_d;
            q_tick_q   <= q_tick_d;
        end
    end

    assign space_ok = (q_len_i < DEPTH_L);

    always_comb begin
        state_d   = state_q;
        q_data_d  = q_data_q;
        ack_d     = ack_q;
        stall_d   = stall_q;
        err_d     = err_q;
        to_d      = to_q;
        stall_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (des_ready_i) begin
                    if (space_ok) begin
                        q_data_d = des_data_i;
                        state_d  = ENQ;
                    end else begin
                        state_d   = STALL;
                        stall_d   = 1'b1;
                        stall_evt = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!des_ready_i) begin
                    state_d = IDLE;
                    stall_d = 1'b0;
                end else if (space_ok) begin
                    q_data_d = des_data_i;
                    state_d  = ENQ;
                    stall_d  = 1'b0;
                end
            end
            // Only a tick seen while already in ENQ fires the strobe.
            ENQ: begin
                if (q_tick_q) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    to_d    = '0;
                end
            end
            ACK: begin
                if (!des_ready_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else if (to_q == TO_LAST) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            q_data_q <= 8'h00;
            ack_q    <= 1'b0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            q_data_q <= q_data_d;
            ack_q    <= ack_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign des_tick_o  = des_tick_q;
    assign q_tick_o    = q_tick_q;
    assign q_enqueue_o = (state_q == ENQ) & q_tick_q;
    assign q_data_o    = q_data_q;
    assign des_ack_o   = ack_q;
    assign stall_o     = stall_q;
    assign err_o       = err_q;

`ifdef XFER_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (q_enqueue_o) xfer_cnt_d = xfer_cnt_q + 16'd1;
        if (stall_evt) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xfer_cnt_o  = xfer_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_evt;
    assign unused_stall_evt = stall_evt;
`endif

endmodule

// File: tb/tb_xfer_sched.sv
// Scoreboard bench for xfer_sched: bytes offered to the controller are queued as expected
// enqueues; a monitor checks every strobe and the tick timing against cycle arithmetic.
module tb_xfer_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       des_tick_o, q_tick_o;
    logic [7:0] des_data_i;
    logic       des_ready_i;
    logic       des_ack_o;
    logic [3:0] q_len_i;
    logic [7:0] q_data_o;
    logic       q_enqueue_o, stall_o, err_o;
`ifdef XFER_STATS_EN
    logic [15:0] xfer_cnt_o, stall_cnt_o;
`endif

    xfer_sched dut (
        .clk         (clk),
        .reset       (reset),
        .des_tick_o  (des_tick_o),
        .q_tick_o    (q_tick_o),
        .des_data_i  (des_data_i),
        .des_ready_i (des_ready_i),
        .des_ack_o   (des_ack_o),
        .q_len_i     (q_len_i),
        .q_data_o    (q_data_o),
        .q_enqueue_o (q_enqueue_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
`ifdef XFER_STATS_EN
        ,
        .xfer_cnt_o  (xfer_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    bit         started = 0;
    bit         auto_q = 0;
    int         occ = 0;
    int         enq_cnt = 0;
    int         stall_model = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycles since the last edge that sampled reset high.
    initial forever begin
        @(posedge clk);
        if (reset) cyc = 0;
        else cyc = cyc + 1;
    end

    // Advance one cycle; in auto mode also act as the queue (fill on strobe, random drain).
    task automatic step();
        bit enq_seen;
        @(negedge clk);
        enq_seen = q_enqueue_o;
        @(posedge clk);
        #1;
        if (auto_q) begin
            if (enq_seen) occ++;
            if (occ > 0 && $urandom_range(0, 199) == 0) occ--;
            q_len_i = 4'(occ);
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (des_ack_o) begin
                ok = 1;
                return;
            end
            step();
        end
    endtask

    task automatic xfer(input logic [7:0] d, input int hold);
        bit         ok;
        logic [3:0] lenv;
        exp_q.push_back(d);
        des_data_i  = d;
        des_ready_i = 1'b1;
        lenv        = q_len_i;
        step();
        if (lenv >= 4'd8) begin
            stall_model++;
            chk("stall_on_full", int'(stall_o), 1);
        end else begin
            chk("latch_data", int'(q_data_o), int'(d));
            chk("no_stall", int'(stall_o), 0);
        end
        wait_ack(ok);
        chk("ack_arrives", int'(ok), 1);
        if (ok) begin
            repeat (hold) step();
            chk("ack_held", int'(des_ack_o), 1);
        end
        des_ready_i = 1'b0;
        step();
        chk("ack_drops", int'(des_ack_o), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_des_tick"}, int'(des_tick_o), 0);
        chk({tag, "_q_tick"}, int'(q_tick_o), 0);
        chk({tag, "_ack"}, int'(des_ack_o), 0);
        chk({tag, "_data"}, int'(q_data_o), 0);
        chk({tag, "_enq"}, int'(q_enqueue_o), 0);
        chk({tag, "_stall"}, int'(stall_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
    endtask

    // Monitor: tick timing from cycle arithmetic, strobes against the expected-byte queue.
    initial begin
        bit         prev_enq = 0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("des_tick_timing", int'(des_tick_o), int'(cyc % 10 == 9));
                chk("q_tick_timing", int'(q_tick_o), int'(cyc % 100 == 99));
                if (reset) enq_cnt = 0;
                if (prev_enq) chk("ack_after_enq", int'(des_ack_o), 1);
                if (q_enqueue_o) begin
                    enq_cnt++;
                    chk("enq_on_tick", int'(q_tick_o), 1);
                    chk("enq_space", int'(q_len_i < 4'd8), 1);
                    chk("enq_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("enq_data", int'(q_data_o), int'(e));
                    end
                end
                prev_enq = q_enqueue_o;
            end
        end
    end

    initial begin
        bit ok;
        int n;
        int ticks;
        int enqs;
        reset       = 1'b1;
        des_ready_i = 1'b0;
        des_data_i  = 8'h00;
        q_len_i     = 4'd0;
        @(posedge clk);
        #1;
        started = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all_zero("reset");

        // Basic transfer with room in the queue.
        repeat (5) step();
        q_len_i = 4'd3;
        xfer(8'hA5, 2);

        // Full queue: hold the byte across three queue ticks, then release space.
        q_len_i     = 4'd8;
        des_data_i  = 8'h3C;
        des_ready_i = 1'b1;
        step();
        chk("full_stall", int'(stall_o), 1);
        chk("full_data_held", int'(q_data_o), 8'hA5);
        ticks = 0;
        enqs  = 0;
        for (int i = 0; i < 400 && ticks < 3; i++) begin
            step();
            if (q_tick_o) ticks++;
            if (q_enqueue_o) enqs++;
        end
        chk("full_ticks_seen", ticks, 3);
        chk("full_no_enq", enqs, 0);
        chk("full_still_stalled", int'(stall_o), 1);
        q_len_i = 4'd7;
        exp_q.push_back(8'h3C);
        step();
        chk("unstall_data", int'(q_data_o), 8'h3C);
        chk("unstall_stall", int'(stall_o), 0);
        wait_ack(ok);
        chk("unstall_ack", int'(ok), 1);
        des_ready_i = 1'b0;
        step();
        chk("unstall_ack_drop", int'(des_ack_o), 0);

        // Byte withdrawn while stalled: nothing is enqueued.
        q_len_i     = 4'd8;
        des_data_i  = 8'h99;
        des_ready_i = 1'b1;
        step();
        chk("withdraw_stall", int'(stall_o), 1);
        repeat (3) step();
        des_ready_i = 1'b0;
        step();
        chk("withdraw_unstall", int'(stall_o), 0);
        q_len_i = 4'd3;
        repeat (150) step();

        // Ack timeout: ready held after the enqueue.
        exp_q.push_back(8'h5A);
        des_data_i  = 8'h5A;
        des_ready_i = 1'b1;
        step();
        wait_ack(ok);
        chk("to_ack", int'(ok), 1);
        n = 0;
        while (des_ack_o && n < 200) begin
            n++;
            step();
        end
        des_ready_i = 1'b0;
        chk("to_ack_cycles", n, 64);
        chk("to_err", int'(err_o), 1);
        chk("to_ack_low", int'(des_ack_o), 0);
        repeat (20) step();
        chk("to_err_sticky", int'(err_o), 1);

        // Reset while waiting in ENQ: byte abandoned, everything cleared.
        for (int i = 0; i < 200 && (cyc % 100) != 10; i++) step();
        des_data_i  = 8'h77;
        des_ready_i = 1'b1;
        step();
        chk("enq_wait_data", int'(q_data_o), 8'h77);
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        des_ready_i = 1'b0;
        chk_all_zero("mid_reset");
        repeat (120) step();

        // Randomized transfers against a draining queue.
        stall_model = 0;
        occ         = 0;
        q_len_i     = 4'd0;
        auto_q      = 1;
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 30)) step();
            xfer(8'($urandom_range(0, 255)), $urandom_range(0, 20));
        end
        auto_q = 0;
        repeat (5) step();
        chk("no_err_random", int'(err_o), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
`ifdef XFER_STATS_EN
        chk("stats_xfer", int'(xfer_cnt_o), enq_cnt);
        chk("stats_stall", int'(stall_cnt_o), stall_model);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
